mem_pipeline_q: RTL and testbench

- Queued, in-order memory micro-op pipeline between the execute/dispatch stage and the blocking L1 data cache port.
- Accepts up to DEPTH micro-ops (m_ld, m_st, m_clflush, m_mnop) without stalling the producer.
- Issues them to the cache one at a time in program order and returns each completed op, with load data merged into dst_val, on a one-cycle out_ready pulse.
- Adds an error path for unknown opcodes and an occupancy output.

---
 rtl/mem_pipeline_q_pkg.sv | 58 +++++
 rtl/mem_pipeline_q_mop_fifo.sv | 63 ++++++
 rtl/mem_pipeline_q.sv | 107 ++++++++++
 tb/tb_mem_pipeline_q.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pipeline_q_pkg.sv
// Shared types for the memory micro-op pipeline: micro-op layout, cache command
// encoding, FSM states and the byte-order helpers used at the cache boundary.
package mem_pipeline_q_pkg;

    localparam logic [7:0] m_mnop    = 8'h00;
    localparam logic [7:0] m_ld      = 8'h01;
    localparam logic [7:0] m_st      = 8'h02;
    localparam logic [7:0] m_clflush = 8'h03;

    typedef struct packed {
        logic [63:0] val;
    } operand_t;

    typedef struct packed {
        logic [7:0] opcode;
        operand_t   dst_val;
        operand_t   src0_val;
        operand_t   src1_val;
    } micro_op_t;

    typedef enum logic [1:0] {IDLE, READ, WRITE, FLUSH} cache_cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} mp_state_t;

    typedef struct packed {
        cache_cmd_t cmd;
        logic       known;
    } cmd_decode_t;

    // Unknown opcodes map to IDLE so they retire without touching the cache.
    function automatic cmd_decode_t mop_to_cache_cmd(input logic [7:0] opcode);
        cmd_decode_t r;
        r.cmd   = IDLE;
        r.known = 1'b1;
        case (opcode)
            m_ld:      r.cmd = READ;
            m_st:      r.cmd = WRITE;
            m_clflush: r.cmd = FLUSH;
            m_mnop:    r.cmd = IDLE;
            default:   r.known = 1'b0;
        endcase
        return r;
    endfunction

    // Byte i of the bus carries bits [8i+7:8i] of the value.
    function automatic logic [63:0] val_to_le_8bytes(input logic [63:0] v);
        logic [63:0] b;
        for (int i = 0; i < 8; i++) b[8*i +: 8] = v[8*i +: 8];
        return b;
    endfunction

    function automatic logic [63:0] le_8bytes_to_val(input logic [63:0] b);
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[8*i +: 8] = b[8*i +: 8];
        return v;
    endfunction

endpackage

// File: rtl/mem_pipeline_q_mop_fifo.sv
// Circular-buffer FIFO with occupancy count; element type is a parameter so
// other pipelines can reuse it. A push into a full queue is always refused.
module mem_pipeline_q_mop_fifo #(
    parameter int  DEPTH  = 4,
    parameter int  CNT_W  = $clog2(DEPTH) + 1,
    parameter type elem_t = logic [7:0]
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  elem_t            push_data,
    input  logic             pop,
    output elem_t            head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;
    elem_t            mem_q [DEPTH];

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/mem_pipeline_q.sv
// In-order memory micro-op pipeline: queues ops from dispatch and issues them one
// at a time to a blocking L1 port, returning each completed op on a single pulse.
module mem_pipeline_q
    import mem_pipeline_q_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_ready,
    input  micro_op_t        in_mop,
    output logic             busy,
    output logic [CNT_W-1:0] occupancy,
    output logic             out_ready,
    output micro_op_t        out_mop,
    output logic             err_unknown,
    output cache_cmd_t       ca_req_cmd,
    output logic [63:0]      ca_req_addr,
    output logic [63:0]      ca_req_data,
    input  logic             ca_respcyc,
    input  logic [63:0]      ca_resp_data
);

    mp_state_t   state_q, state_d;
    micro_op_t   head;
    micro_op_t   out_mop_q, out_mop_d;
    logic        err_q, err_d;
    logic        ovf_seen_q, ovf_seen_d;
    logic        fifo_empty;
    logic        pop;
    cmd_decode_t head_dec;

    mem_pipeline_q_mop_fifo #(
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W),
        .elem_t (micro_op_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_ready),
        .push_data (in_mop),
        .pop       (pop),
        .head      (head),
        .full      (busy),
        .empty     (fifo_empty),
        .count     (occupancy)
    );

    assign head_dec    = mop_to_cache_cmd(head.opcode);
    assign ovf_seen_d  = ovf_seen_q | (in_ready & busy);
    assign out_ready   = (state_q == S_DONE);
    assign err_unknown = (state_q == S_DONE) && err_q;
    assign out_mop     = out_mop_q;

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        out_mop_d   = out_mop_q;
        err_d       = err_q;
        ca_req_cmd  = IDLE;
        ca_req_addr = head.src0_val.val;
        ca_req_data = '0;
        if (head.opcode == m_st) begin
            ca_req_addr = head.src1_val.val;
            ca_req_data = val_to_le_8bytes(head.src0_val.val);
        end
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) state_d = S_REQ;
            end
            S_REQ: begin
                ca_req_cmd = head_dec.cmd;
                // Ops without a cache command retire in their first request cycle.
                if (head_dec.cmd == IDLE || ca_respcyc) begin
                    pop       = 1'b1;
                    state_d   = S_DONE;
                    out_mop_d = head;
                    err_d     = !head_dec.known;
                    if (head.opcode == m_ld)
                        out_mop_d.dst_val.val = le_8bytes_to_val(ca_resp_data);
                end
            end
            S_DONE: begin
                state_d = fifo_empty ? S_IDLE : S_REQ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            err_q      <= 1'b0;
            ovf_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            ovf_seen_q <= ovf_seen_d;
        end
    end

    always_ff @(posedge clk) begin
        out_mop_q <= out_mop_d;
    end

endmodule

// File: tb/tb_mem_pipeline_q.sv
// Scoreboard bench for mem_pipeline_q: expected completions are queued at push
// time and compared by a monitor on every out_ready pulse.
module tb_mem_pipeline_q;
    import mem_pipeline_q_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_ready;
    micro_op_t        in_mop;
    logic             busy;
    logic [CNT_W-1:0] occupancy;
    logic             out_ready;
    micro_op_t        out_mop;
    logic             err_unknown;
    cache_cmd_t       ca_req_cmd;
    logic [63:0]      ca_req_addr;
    logic [63:0]      ca_req_data;
    logic             ca_respcyc;
    logic [63:0]      ca_resp_data;

    int total = 0;
    int bad   = 0;
    int out_cnt = 0;

    micro_op_t exp_q[$];
    logic      exp_err_q[$];
    micro_op_t mon_e;
    logic      mon_ee;

    mem_pipeline_q #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_ready     (in_ready),
        .in_mop       (in_mop),
        .busy         (busy),
        .occupancy    (occupancy),
        .out_ready    (out_ready),
        .out_mop      (out_mop),
        .err_unknown  (err_unknown),
        .ca_req_cmd   (ca_req_cmd),
        .ca_req_addr  (ca_req_addr),
        .ca_req_data  (ca_req_data),
        .ca_respcyc   (ca_respcyc),
        .ca_resp_data (ca_resp_data)
    );

    always #5 clk = ~clk;

    function automatic micro_op_t mk(input logic [7:0] opc, input logic [63:0] d,
                                     input logic [63:0] s0, input logic [63:0] s1);
        micro_op_t m;
        m.opcode       = opc;
        m.dst_val.val  = d;
        m.src0_val.val = s0;
        m.src1_val.val = s1;
        return m;
    endfunction

    // Reference byte-order model: byte i of the bus is (value >> 8i) & 0xFF.
    function automatic logic [63:0] model_to_bytes(input logic [63:0] v);
        logic [63:0] b = '0;
        for (int i = 0; i < 8; i++) b = b | ((((v >> (8*i)) & 64'hFF)) << (8*i));
        return b;
    endfunction

    function automatic logic [63:0] model_from_bytes(input logic [63:0] b);
        logic [63:0] v = '0;
        for (int i = 0; i < 8; i++) v = v + ((b >> (8*i)) & 64'hFF) * (64'd1 << (8*i));
        return v;
    endfunction

    always @(negedge clk) begin
        if (!reset && out_ready) begin
            out_cnt++;
            $display("out #%0d opcode=%h dst=%h src0=%h src1=%h err=%b", out_cnt,
                     out_mop.opcode, out_mop.dst_val.val, out_mop.src0_val.val,
                     out_mop.src1_val.val, err_unknown);
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL out_unexpected: got opcode %h, required no output", out_mop.opcode);
            end else begin
                mon_e  = exp_q.pop_front();
                mon_ee = exp_err_q.pop_front();
                if (out_mop !== mon_e) begin
                    bad++;
                    $display("FAIL out_mop: got %h, required %h", out_mop, mon_e);
                end
                total++;
                if (err_unknown !== mon_ee) begin
                    bad++;
                    $display("FAIL err_unknown: got %b, required %b", err_unknown, mon_ee);
                end
            end
        end
    end

    task automatic push_op(input micro_op_t op, input micro_op_t exp_out, input logic exp_err);
        in_ready = 1'b1;
        in_mop   = op;
        exp_q.push_back(exp_out);
        exp_err_q.push_back(exp_err);
        @(negedge clk);
        in_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_ready = 1'b0;
        in_mop = '0;
        ca_respcyc = 1'b0;
        ca_resp_data = '0;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b, required 0", busy); end
        total++; if (occupancy !== '0) begin bad++; $display("FAIL rst_occ: got %0d, required 0", occupancy); end
        total++; if (out_ready !== 1'b0) begin bad++; $display("FAIL rst_out_ready: got %b, required 0", out_ready); end
        total++; if (err_unknown !== 1'b0) begin bad++; $display("FAIL rst_err: got %b, required 0", err_unknown); end
        total++; if (ca_req_cmd !== IDLE) begin bad++; $display("FAIL rst_cmd: got %s, required IDLE", ca_req_cmd.name()); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load();
        micro_op_t op, e;
        logic [63:0] rdata = 64'h0807060504030201;
        op = mk(m_ld, 64'h55, 64'h1000, 64'h0);
        e = op;
        e.dst_val.val = model_from_bytes(rdata);
        push_op(op, e, 1'b0);
        total++; if (ca_req_cmd !== IDLE) begin bad++; $display("FAIL ld_early_cmd: got %s, required IDLE", ca_req_cmd.name()); end
        total++; if (occupancy !== 3'd1) begin bad++; $display("FAIL ld_occ: got %0d, required 1", occupancy); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if (ca_req_cmd !== READ) begin bad++; $display("FAIL ld_cmd[%0d]: got %s, required READ", k, ca_req_cmd.name()); end
            total++; if (ca_req_addr !== 64'h1000) begin bad++; $display("FAIL ld_addr[%0d]: got %h, required 1000", k, ca_req_addr); end
            total++; if (out_ready !== 1'b0) begin bad++; $display("FAIL ld_early_out[%0d]: got %b, required 0", k, out_ready); end
        end
        ca_respcyc = 1'b1;
        ca_resp_data = rdata;
        @(negedge clk);
        ca_respcyc = 1'b0;
        total++; if (out_ready !== 1'b1) begin bad++; $display("FAIL ld_out_ready: got %b, required 1", out_ready); end
        total++; if (ca_req_cmd !== IDLE) begin bad++; $display("FAIL ld_done_cmd: got %s, required IDLE", ca_req_cmd.name()); end
        @(negedge clk);
        total++; if (out_ready !== 1'b0) begin bad++; $display("FAIL ld_pulse_width: got %b, required 0", out_ready); end
    endtask

    task automatic test_store();
        micro_op_t op;
        op = mk(m_st, 64'h77, 64'hDEADBEEF, 64'h2000);
        push_op(op, op, 1'b0);
        @(negedge clk);
        total++; if (ca_req_cmd !== WRITE) begin bad++; $display("FAIL st_cmd: got %s, required WRITE", ca_req_cmd.name()); end
        total++; if (ca_req_addr !== 64'h2000) begin bad++; $display("FAIL st_addr: got %h, required 2000", ca_req_addr); end
        total++; if (ca_req_data !== model_to_bytes(64'hDEADBEEF)) begin bad++; $display("FAIL st_data: got %h, required %h", ca_req_data, model_to_bytes(64'hDEADBEEF)); end
        ca_respcyc = 1'b1;
        ca_resp_data = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        ca_respcyc = 1'b0;
        total++; if (out_ready !== 1'b1) begin bad++; $display("FAIL st_out_ready: got %b, required 1", out_ready); end
        @(negedge clk);
    endtask

    task automatic test_overflow();
        micro_op_t op, e;
        int start_cnt = out_cnt;
        int waited;
        logic [63:0] rd = 64'h1111_2222_3333_4444;
        ca_resp_data = rd;
        for (int i = 0; i < 5; i++) begin
            op = mk(m_ld, 64'(i), 64'h100 * 64'(i + 1), 64'h0);
            e = op;
            e.dst_val.val = model_from_bytes(rd);
            in_ready = 1'b1;
            in_mop = op;
            if (i < 4) begin
                exp_q.push_back(e);
                exp_err_q.push_back(1'b0);
            end
            @(negedge clk);
            total++; if (busy !== (i >= 3)) begin bad++; $display("FAIL ovf_busy[%0d]: got %b, required %b", i, busy, (i >= 3)); end
            total++; if (occupancy !== CNT_W'((i < 4) ? i + 1 : 4)) begin bad++; $display("FAIL ovf_occ[%0d]: got %0d, required %0d", i, occupancy, (i < 4) ? i + 1 : 4); end
        end
        in_ready = 1'b0;
        total++; if (dut.ovf_seen_q !== 1'b1) begin bad++; $display("FAIL ovf_seen: got %b, required 1", dut.ovf_seen_q); end
        for (int j = 0; j < 4; j++) begin
            waited = 0;
            while (ca_req_cmd === IDLE && waited < 10) begin
                @(negedge clk);
                waited++;
            end
            total++; if (ca_req_cmd !== READ) begin bad++; $display("FAIL ovf_drain_cmd[%0d]: got %s, required READ", j, ca_req_cmd.name()); end
            total++; if (ca_req_addr !== 64'h100 * 64'(j + 1)) begin bad++; $display("FAIL ovf_drain_addr[%0d]: got %h, required %h", j, ca_req_addr, 64'h100 * 64'(j + 1)); end
            ca_respcyc = 1'b1;
            @(negedge clk);
            ca_respcyc = 1'b0;
        end
        @(negedge clk);
        total++; if (occupancy !== '0) begin bad++; $display("FAIL ovf_final_occ: got %0d, required 0", occupancy); end
        total++; if (out_cnt - start_cnt !== 4) begin bad++; $display("FAIL ovf_pulses: got %0d, required 4", out_cnt - start_cnt); end
    endtask

    task automatic test_mnop_unknown();
        micro_op_t op0, op1;
        logic exp_rdy [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic exp_err [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        op0 = mk(m_mnop, 64'hAA, 64'h9000, 64'h0);
        op1 = mk(8'hFF, 64'hBB, 64'h9100, 64'h0);
        in_ready = 1'b1;
        in_mop = op0;
        exp_q.push_back(op0); exp_err_q.push_back(1'b0);
        @(negedge clk);
        in_mop = op1;
        exp_q.push_back(op1); exp_err_q.push_back(1'b1);
        @(negedge clk);
        in_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            total++; if (ca_req_cmd !== IDLE) begin bad++; $display("FAIL nop_cmd[%0d]: got %s, required IDLE", k, ca_req_cmd.name()); end
            total++; if (out_ready !== exp_rdy[k]) begin bad++; $display("FAIL nop_out_ready[%0d]: got %b, required %b", k, out_ready, exp_rdy[k]); end
            total++; if (err_unknown !== exp_err[k]) begin bad++; $display("FAIL nop_err[%0d]: got %b, required %b", k, err_unknown, exp_err[k]); end
        end
    endtask

    task automatic test_interleave();
        micro_op_t ld, fl, st, e;
        logic [63:0] rd = 64'hA1B2C3D4E5F60718;
        cache_cmd_t exp_cmd [8] = '{IDLE, READ, IDLE, FLUSH, IDLE, WRITE, IDLE, IDLE};
        int exp_occ [8] = '{1, 2, 2, 2, 1, 1, 0, 0};
        logic [63:0] exp_addr [8] = '{64'h0, 64'h3000, 64'h0, 64'h4000, 64'h0, 64'h5000, 64'h0, 64'h0};
        ld = mk(m_ld, 64'h11, 64'h3000, 64'h0);
        fl = mk(m_clflush, 64'h22, 64'h4000, 64'h0);
        st = mk(m_st, 64'h33, 64'h1122334455667788, 64'h5000);
        ca_resp_data = rd;
        e = ld;
        e.dst_val.val = model_from_bytes(rd);
        in_ready = 1'b1;
        in_mop = ld;
        exp_q.push_back(e);  exp_err_q.push_back(1'b0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) begin
                in_mop = fl; exp_q.push_back(fl); exp_err_q.push_back(1'b0);
            end else if (k == 1) begin
                in_mop = st; exp_q.push_back(st); exp_err_q.push_back(1'b0);
            end else begin
                in_ready = 1'b0;
            end
            total++; if (occupancy !== CNT_W'(exp_occ[k])) begin bad++; $display("FAIL mix_occ[%0d]: got %0d, required %0d", k, occupancy, exp_occ[k]); end
            total++; if (ca_req_cmd !== exp_cmd[k]) begin bad++; $display("FAIL mix_cmd[%0d]: got %s, required %s", k, ca_req_cmd.name(), exp_cmd[k].name()); end
            if (exp_cmd[k] != IDLE) begin
                total++; if (ca_req_addr !== exp_addr[k]) begin bad++; $display("FAIL mix_addr[%0d]: got %h, required %h", k, ca_req_addr, exp_addr[k]); end
            end
            if (exp_cmd[k] == WRITE) begin
                total++; if (ca_req_data !== model_to_bytes(64'h1122334455667788)) begin bad++; $display("FAIL mix_st_data: got %h, required %h", ca_req_data, model_to_bytes(64'h1122334455667788)); end
            end
            ca_respcyc = (exp_cmd[k] != IDLE);
        end
        ca_respcyc = 1'b0;
    endtask

    task automatic test_reset_mid();
        micro_op_t op;
        int start_cnt;
        op = mk(m_ld, 64'h66, 64'h7000, 64'h0);
        in_ready = 1'b1;
        in_mop = op;
        @(negedge clk);
        in_ready = 1'b0;
        @(negedge clk);
        total++; if (ca_req_cmd !== READ) begin bad++; $display("FAIL rm_cmd_pending: got %s, required READ", ca_req_cmd.name()); end
        start_cnt = out_cnt;
        reset = 1'b1;
        @(negedge clk);
        total++; if (ca_req_cmd !== IDLE) begin bad++; $display("FAIL rm_cmd: got %s, required IDLE", ca_req_cmd.name()); end
        total++; if (occupancy !== '0) begin bad++; $display("FAIL rm_occ: got %0d, required 0", occupancy); end
        reset = 1'b0;
        ca_respcyc = 1'b1;
        ca_resp_data = 64'hDEAD;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if (out_ready !== 1'b0) begin bad++; $display("FAIL rm_out_ready[%0d]: got %b, required 0", k, out_ready); end
            total++; if (ca_req_cmd !== IDLE) begin bad++; $display("FAIL rm_stray_cmd[%0d]: got %s, required IDLE", k, ca_req_cmd.name()); end
        end
        ca_respcyc = 1'b0;
        total++; if (out_cnt !== start_cnt) begin bad++; $display("FAIL rm_pulses: got %0d, required %0d", out_cnt - start_cnt, 0); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_overflow();
        test_mnop_unknown();
        test_interleave();
        test_reset_mid();
        repeat (2) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover: got %0d pending, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
